fetch_buffer: RTL and testbench

- Instruction prefetch queue between the program counter / instruction memory and the decode stage of the pipelined MIPS core.
- Each cycle the fetch side presents one (address, instruction) pair. The buffer queues it and presents the oldest entry to decode with a valid/ready handshake.
- Its stall output drives the PC hold input, so the PC freezes while the queue is full.
- A flush from branch/jump resolution discards all queued instructions.

---
 rtl/fetch_buffer.sv | 86 ++++++++
 tb/tb_fetch_buffer.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between fetch and decode: circular buffer of
// {addr, instr} pairs with show-ahead head, full-stall to the PC and flush.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetchValid,
    input  logic [31:0]      fetchAddr,
    input  logic [31:0]      fetchInstr,
    input  logic             flush,
    input  logic             decodeReady,
    output logic             fetchStall,
    output logic             decodeValid,
    output logic [31:0]      decodeAddr,
    output logic [31:0]      decodeInstr,
    output logic [31:0]      decodeNextAddr,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;
    entry_t           head;

    // Stall and valid come only from registered count, keeping handshakes
    // free of combinational paths from the inputs.
    assign fetchStall  = (count_q == FULL);
    assign decodeValid = (count_q != '0);
    assign push        = fetchValid && !fetchStall;
    assign pop         = decodeValid && decodeReady;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; an entry is only observable once counted.
    always_ff @(posedge clk) begin
        if (reset && !flush && push)
            mem_q[wr_ptr_q] <= '{addr: fetchAddr, instr: fetchInstr};
    end

    always_comb begin
        head = '0;
        if (decodeValid) head = mem_q[rd_ptr_q];
    end

    assign decodeAddr     = head.addr;
    assign decodeInstr    = head.instr;
    assign decodeNextAddr = head.addr + 32'd4;
    assign occupancy      = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue model tracks expected contents
// and every cycle the DUT head, occupancy and flags are compared against it.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset, fetchValid, flush, decodeReady;
    logic [31:0] fetchAddr, fetchInstr;
    logic        fetchStall, decodeValid;
    logic [31:0] decodeAddr, decodeInstr, decodeNextAddr;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .fetchValid(fetchValid), .fetchAddr(fetchAddr),
        .fetchInstr(fetchInstr), .flush(flush), .decodeReady(decodeReady),
        .fetchStall(fetchStall), .decodeValid(decodeValid), .decodeAddr(decodeAddr),
        .decodeInstr(decodeInstr), .decodeNextAddr(decodeNextAddr), .occupancy(occupancy)
    );

    logic [63:0] sb[$];
    bit          known = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs of the current state against
    // the model, then advance the model across the coming rising edge.
    task automatic step(input bit rs, input bit fv, input logic [31:0] a,
                        input logic [31:0] ins, input bit fl, input bit dr);
        logic [63:0] e;
        int          sz;
        reset = rs; fetchValid = fv; fetchAddr = a; fetchInstr = ins;
        flush = fl; decodeReady = dr;
        #2;
        sz = sb.size();
        if (known) begin
            chk("occupancy", 32'(occupancy), 32'(sz));
            chk("decodeValid", 32'(decodeValid), 32'(sz != 0));
            chk("fetchStall", 32'(fetchStall), 32'(sz == 4));
            if (sz == 0) begin
                chk("empty_addr", decodeAddr, 32'h0);
                chk("empty_next", decodeNextAddr, 32'h4);
            end else begin
                e = sb[0];
                chk("head_addr", decodeAddr, e[63:32]);
                chk("head_instr", decodeInstr, e[31:0]);
                chk("head_next", decodeNextAddr, e[63:32] + 32'd4);
            end
        end
        if (!rs || fl) sb.delete();
        else begin
            if (sz > 0 && dr) void'(sb.pop_front());
            if (fv && sz < 4) sb.push_back({a, ins});
        end
        if (!rs) known = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; fetchValid = 1'b0; fetchAddr = '0; fetchInstr = '0;
        flush = 1'b0; decodeReady = 1'b0;

        // reset held with fetchValid asserted
        step(0, 1, 32'h1000, 32'h1, 0, 0);
        step(0, 1, 32'h1004, 32'h2, 0, 0);
        step(1, 0, 32'h0, 32'h0, 0, 0);

        // fill to full, fifth push ignored, then drain
        for (int k = 0; k < 5; k++)
            step(1, 1, 32'h3000 + 32'(4*k), 32'h24080001 + 32'(k), 0, 0);
        for (int k = 0; k < 4; k++)
            step(1, 0, 32'h0, 32'h0, 0, 1);
        step(1, 0, 32'h0, 32'h0, 0, 1);

        // continuous streaming, pointers wrap several times
        for (int k = 0; k < 20; k++)
            step(1, 1, 32'h3000 + 32'(4*k), 32'hA000 + 32'(k), 0, 1);
        step(1, 0, 32'h0, 32'h0, 0, 1);
        step(1, 0, 32'h0, 32'h0, 0, 1);

        // flush with simultaneous push and pop
        for (int k = 0; k < 3; k++)
            step(1, 1, 32'h3000 + 32'(4*k), 32'hB000 + 32'(k), 0, 0);
        step(1, 1, 32'h3010, 32'hB010, 1, 1);
        step(1, 1, 32'h4000, 32'hC000, 0, 0);
        step(1, 0, 32'h0, 32'h0, 0, 1);
        step(1, 0, 32'h0, 32'h0, 0, 1);

        // reset mid-stream
        step(1, 1, 32'h5000, 32'hD000, 0, 0);
        step(1, 1, 32'h5004, 32'hD001, 0, 0);
        step(0, 1, 32'h5008, 32'hD002, 0, 0);
        step(1, 0, 32'h0, 32'h0, 0, 1);
        step(1, 0, 32'h0, 32'h0, 0, 1);

        // next-address wrap at top of address space
        step(1, 1, 32'hFFFFFFFC, 32'hE000, 0, 0);
        step(1, 0, 32'h0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 32'h0, 0, 1);
        step(1, 0, 32'h0, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
